// File: rtl/alu_exec_unit.sv
// Two-stage valid/ready ALU execution unit: operand capture stage, then a registered result stage.
// Define ALU_OVF_EN to add the registered signed-overflow flag; otherwise ovf is tied 0.
module alu_exec_unit #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 take_br,
  output logic                 illegal,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 ovf
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOR = 4'd5,
    OP_SLT = 4'd6,
    OP_BEQ = 4'd7,
    OP_BNE = 4'd8,
    OP_BLT = 4'd9,
    OP_BGT = 4'd10
  } alu_op_e;

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_s;
  logic             gt_s;
  logic [WIDTH-1:0] res_d;
  logic             br_d;
  logic             ill_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;
  assign accept   = in_valid && in_ready;

  assign sum  = s1_a + s1_b;
  assign diff = s1_a - s1_b;
  assign lt_s = $signed(s1_a) < $signed(s1_b);
  assign gt_s = $signed(s1_a) > $signed(s1_b);

  // Codes 11..15 and any X/Z code fall through to default and are flagged illegal.
  always_comb begin
    res_d = '0;
    br_d  = 1'b0;
    ill_d = 1'b0;
    case (s1_op)
      OP_ADD:  res_d = sum;
      OP_SUB:  res_d = diff;
      OP_AND:  res_d = s1_a & s1_b;
      OP_OR:   res_d = s1_a | s1_b;
      OP_XOR:  res_d = s1_a ^ s1_b;
      OP_NOR:  res_d = ~(s1_a | s1_b);
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, lt_s};
      OP_BEQ:  br_d  = (s1_a == s1_b);
      OP_BNE:  br_d  = (s1_a != s1_b);
      OP_BLT:  br_d  = lt_s;
      OP_BGT:  br_d  = gt_s;
      default: ill_d = 1'b1;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    if (s1_op == OP_ADD)
      ovf_d = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    else if (s1_op == OP_SUB)
      ovf_d = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (adv && s1_valid)
      ovf <= ovf_d;
  end
`else
  assign ovf = 1'b0;
`endif

  // S1 refills whenever it is empty or draining into OUT this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (accept) begin
        s1_op <= alu_op;
        s1_a  <= op_a;
        s1_b  <= op_b;
      end
    end
  end

  // OUT holds until consumed; an empty OUT keeps its last payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      take_br   <= 1'b0;
      illegal   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= res_d;
        take_br <= br_d;
        illegal <= ill_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (out_valid && out_ready && illegal && (err_cnt != {ERR_CNT_W{1'b1}}))
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; honours ALU_OVF_EN for the ovf expectations.
module tb_alu_exec_unit;

  localparam int WIDTH     = 16;
  localparam int ERR_CNT_W = 8;
`ifdef ALU_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           alu_op;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 take_br;
  logic                 illegal;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 ovf;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .take_br(take_br), .illegal(illegal),
    .err_cnt(err_cnt), .ovf(ovf)
  );

  // Called at a negedge; returns at the negedge following the accepting posedge with in_valid still high.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int waitCycles;
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    #1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (!in_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitCycles);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({out_valid, take_br, illegal, ovf} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got v/br/ill/ovf=%b, required 0000", {out_valid, take_br, illegal, ovf});
    end
    testsRun++;
    if (result !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_result: got %h, required 0000", result);
    end
    testsRun++;
    if (err_cnt !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_err_cnt: got %0d, required 0", err_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    applyStimulus(4'd0, 16'h7FFF, 16'h0001);
    in_valid = 1'b0;
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL add_latency_early: out_valid=%b one edge after accept, required 0", out_valid);
    end
    @(negedge clk);
    testsRun++;
    if ({out_valid, result, take_br, illegal, ovf} !== {1'b1, 16'h8000, 1'b0, 1'b0, OVF_ON}) begin
      testsFailed++;
      $display("[TB] FAIL add_7fff_1: got v=%b r=%h br=%b ill=%b ovf=%b, required v=1 r=8000 br=0 ill=0 ovf=%b",
               out_valid, result, take_br, illegal, ovf, OVF_ON);
    end
    @(negedge clk);
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL add_no_duplicate: out_valid=%b after handoff, required 0", out_valid);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  tOp  [16] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                               4'd6, 4'd6, 4'd9, 4'd10, 4'd7, 4'd8, 4'd8, 4'd10};
    logic [15:0] tA   [16] = '{16'h4000, 16'hFFFF, 16'h8000, 16'h0005, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0,
                               16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0005, 16'h0005, 16'h0005, 16'h7FFF};
    logic [15:0] tB   [16] = '{16'h4000, 16'h0001, 16'h0001, 16'h0007, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0FF0,
                               16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'h0006, 16'h8000};
    logic [15:0] tRes [16] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFE, 16'h00F0, 16'hFFF0, 16'hFF00, 16'h000F,
                               16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        tBr  [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        tOvf [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        expOvf;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tOp[i], tA[i], tB[i]);
      in_valid = 1'b0;
      @(negedge clk);
      expOvf = tOvf[i] & OVF_ON;
      testsRun++;
      if ({out_valid, result, take_br, illegal, ovf} !== {1'b1, tRes[i], tBr[i], 1'b0, expOvf}) begin
        testsFailed++;
        $display("[TB] FAIL op_vec%0d(op=%0d a=%h b=%h): got v=%b r=%h br=%b ill=%b ovf=%b, required v=1 r=%h br=%b ill=0 ovf=%b",
                 i, tOp[i], tA[i], tB[i], out_valid, result, take_br, illegal, ovf, tRes[i], tBr[i], expOvf);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] probe;
    logic [3:0] zOp;
    probe = 4'bzzzz;
    zOp   = (probe === 4'bzzzz) ? 4'bzzzz : 4'hD;
    out_ready = 1'b1;
    applyStimulus(4'hC, 16'h1234, 16'h0001);
    in_valid = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({out_valid, illegal, result, take_br} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL illegal_c: got v=%b ill=%b r=%h br=%b, required v=1 ill=1 r=0000 br=0",
               out_valid, illegal, result, take_br);
    end
    applyStimulus(zOp, 16'h00FF, 16'h00FF);
    in_valid = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({out_valid, illegal, result, take_br} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL illegal_z: got v=%b ill=%b r=%h br=%b, required v=1 ill=1 r=0000 br=0",
               out_valid, illegal, result, take_br);
    end
    @(negedge clk);
    testsRun++;
    if (err_cnt !== 8'd2) begin
      testsFailed++;
      $display("[TB] FAIL err_cnt_two: got %0d, required 2", err_cnt);
    end
    applyStimulus(4'd0, 16'h0001, 16'h0001);
    in_valid = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({illegal, result} !== {1'b0, 16'h0002}) begin
      testsFailed++;
      $display("[TB] FAIL legal_after_illegal: got ill=%b r=%h, required ill=0 r=0002", illegal, result);
    end
    @(negedge clk);
    testsRun++;
    if (err_cnt !== 8'd2) begin
      testsFailed++;
      $display("[TB] FAIL err_cnt_legal_hold: got %0d, required 2", err_cnt);
    end
    for (int i = 0; i < 300; i++)
      applyStimulus(4'hF, 16'(i), 16'h0000);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (err_cnt !== 8'd255) begin
      testsFailed++;
      $display("[TB] FAIL err_cnt_saturate: got %0d, required 255", err_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] expRes [4] = '{16'h0111, 16'h0211, 16'h0311, 16'h0411};
    logic [4:0]  rdy;
    int          sent;
    int          rcv;
    sent = 0;
    rcv  = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (sent < 4) begin
        in_valid = 1'b1; alu_op = 4'd0; op_a = 16'h0100 * 16'(sent + 1); op_b = 16'h0011;
      end else
        in_valid = 1'b0;
      #1;
      rdy[c] = in_ready;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    testsRun++;
    if (rdy !== 5'b00011) begin
      testsFailed++;
      $display("[TB] FAIL bp_ready_pattern: got %b (cycle0 at lsb), required 00011", rdy);
    end
    testsRun++;
    if (sent !== 2) begin
      testsFailed++;
      $display("[TB] FAIL bp_accepted: got %0d accepted while stalled, required 2", sent);
    end
    testsRun++;
    if ({out_valid, result} !== {1'b1, expRes[0]}) begin
      testsFailed++;
      $display("[TB] FAIL bp_hold: got v=%b r=%h, required v=1 r=%h", out_valid, result, expRes[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        testsRun++;
        if (rcv >= 4) begin
          testsFailed++;
          $display("[TB] FAIL bp_extra: got extra result %h, required none", result);
        end else if (result !== expRes[rcv]) begin
          testsFailed++;
          $display("[TB] FAIL bp_order%0d: got %h, required %h", rcv, result, expRes[rcv]);
        end
        rcv++;
      end
      if (sent < 4) begin
        in_valid = 1'b1; alu_op = 4'd0; op_a = 16'h0100 * 16'(sent + 1); op_b = 16'h0011;
      end else
        in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    testsRun++;
    if (rcv !== 4) begin
      testsFailed++;
      $display("[TB] FAIL bp_count: got %0d results, required 4", rcv);
    end
  endtask

  task automatic test_back_to_back();
    int rcv;
    int firstC;
    int lastC;
    int notReady;
    logic [15:0] expR;
    rcv = 0; firstC = -1; lastC = -1; notReady = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) begin
        if (firstC < 0) firstC = c;
        lastC = c;
        expR = (rcv % 2 == 0) ? 16'h2100 + 16'(8 * rcv) : 16'h1F00 + 16'(6 * rcv);
        testsRun++;
        if (result !== expR) begin
          testsFailed++;
          $display("[TB] FAIL stream_res%0d: got %h, required %h", rcv, result, expR);
        end
        rcv++;
      end
      if (c < 20) begin
        in_valid = 1'b1;
        alu_op   = (c % 2 == 0) ? 4'd0 : 4'd1;
        op_a     = 16'h2000 + 16'(7 * c);
        op_b     = 16'h0100 + 16'(c);
      end else
        in_valid = 1'b0;
      #1;
      if (in_valid && !in_ready) notReady++;
      @(negedge clk);
    end
    testsRun++;
    if (rcv !== 20 || (lastC - firstC) !== 19) begin
      testsFailed++;
      $display("[TB] FAIL stream_count: got %0d results over span %0d, required 20 over span 19", rcv, lastC - firstC);
    end
    testsRun++;
    if (notReady !== 0) begin
      testsFailed++;
      $display("[TB] FAIL stream_in_ready: got %0d stalled cycles, required 0", notReady);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    applyStimulus(4'd0, 16'h0010, 16'h0020);
    applyStimulus(4'd1, 16'h0050, 16'h0020);
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, err_cnt} !== {1'b1, 8'd255}) begin
      testsFailed++;
      $display("[TB] FAIL midrst_pre: got v=%b err_cnt=%0d, required v=1 err_cnt=255", out_valid, err_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({out_valid, err_cnt, result, in_ready} !== {1'b0, 8'd0, 16'h0000, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL midrst_async: got v=%b err_cnt=%0d r=%h rdy=%b, required v=0 err_cnt=0 r=0000 rdy=1",
               out_valid, err_cnt, result, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(4'd0, 16'h0002, 16'h0003);
    in_valid = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({out_valid, result} !== {1'b1, 16'h0005}) begin
      testsFailed++;
      $display("[TB] FAIL midrst_first_op: got v=%b r=%h, required v=1 r=0005", out_valid, result);
    end
    @(negedge clk);
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_flushed: out_valid=%b with r=%h, required 0", out_valid, result);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
